// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the scheduler state encoding and the UART byte width.
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational one-hot round-robin pick.
// The search starts one position after the last granted index.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    always_comb begin
        int  j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int s = 1; s <= N; s++) begin
            j = (int'(last) + s) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ producers.
// Define UART_TX_SCHED_LOCK_EN to keep a requester granted until its REQ_LAST byte.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int BUSY_TIMEOUT = 4,
    localparam int GW           = $clog2(N_REQ),
    localparam int CW           = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         REQ_VALID,
    input  logic [UART_DW*N_REQ-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]         REQ_LAST,
    output logic [N_REQ-1:0]         REQ_READY,
    output logic                     TX_EN,
    output logic [UART_DW-1:0]       TX_DATA,
    input  logic                     TX_STATUS,
    output logic [GW-1:0]            GRANT_ID,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR
);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pick;
    logic [GW-1:0]   pick_id;
    logic            grant;
    logic            timeout;

    assign timeout = (state == WAIT_BUSY) && (cnt == CW'(BUSY_TIMEOUT));

`ifdef UART_TX_SCHED_LOCK_EN
    logic locked;

    // While locked only the owner of the burst may win, valid or not.
    assign elig = locked ? (REQ_VALID & (N_REQ'(1) << GRANT_ID)) : REQ_VALID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (grant) begin
            locked <= !REQ_LAST[pick_id];
        end else if (timeout) begin
            locked <= 1'b0;
        end
    end
`else
    logic unused_last;

    assign elig        = REQ_VALID;
    assign unused_last = ^REQ_LAST;
`endif

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req  (elig),
        .last (GRANT_ID),
        .gnt  (pick),
        .idx  (pick_id)
    );

    // Gated by rst_n so no byte is taken while reset is held.
    assign grant     = rst_n && (state == IDLE) && TX_STATUS && (|elig);
    assign REQ_READY = grant ? pick : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            TX_EN    <= 1'b0;
            TX_DATA  <= '0;
            GRANT_ID <= GW'(N_REQ - 1);
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            TX_EN <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        TX_DATA  <= REQ_DATA[int'(pick_id)*UART_DW +: UART_DW];
                        GRANT_ID <= pick_id;
                        TX_EN    <= 1'b1;
                        BUSY     <= 1'b1;
                        cnt      <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // ERR is already high in the cycle the counter hits the limit.
                    if (timeout) begin
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (!TX_STATUS) begin
                        state <= WAIT_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        ERR <= (cnt + 1'b1) == CW'(BUSY_TIMEOUT);
                    end
                end
                WAIT_DONE: begin
                    if (TX_STATUS) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: per-cycle reference model plus directed scenarios.
// Honours UART_TX_SCHED_LOCK_EN for the burst-lock expectations.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic         tx_en;
    logic [7:0]   tx_data;
    logic         tx_status = 1'b1;
    logic [1:0]   grant_id;
    logic         busy, done, err;

    uart_tx_scheduler #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .REQ_VALID (req_valid),
        .REQ_DATA  (req_data),
        .REQ_LAST  (req_last),
        .REQ_READY (req_ready),
        .TX_EN     (tx_en),
        .TX_DATA   (tx_data),
        .TX_STATUS (tx_status),
        .GRANT_ID  (grant_id),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;
    int cyc = 0;

    task automatic chk(string nm, int act, int exp);
        nchk++;
        if (act != exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        else
            npass++;
    endtask

    always @(posedge clk) cyc++;

    // Transmitter: mode 0 busy for xb cycles after TX_EN, 1 never busy, 2 stuck busy
    int xmode = 0;
    int xb = 9;
    int bcnt = 0;
    always @(posedge clk) begin
        #1;
        if (xmode == 1) tx_status = 1'b1;
        else if (xmode == 2) tx_status = 1'b0;
        else if (bcnt > 0) begin
            tx_status = 1'b0;
            bcnt--;
        end else tx_status = 1'b1;
        if (tx_en && xmode == 0) bcnt = xb;
    end

    // Requesters: per-requester byte queues, advanced on acceptance
    logic [7:0] mem[N][8];
    bit         lm[N][8];
    int         hd[N];
    int         tl[N];
    logic [N-1:0] acc = '0;

    initial for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) hd[i]++;
            req_valid[i] = hd[i] < tl[i];
            req_data[i*8 +: 8] = (hd[i] < tl[i]) ? mem[i][hd[i]] : 8'h00;
            req_last[i] = (hd[i] < tl[i]) ? lm[i][hd[i]] : 1'b0;
        end
        acc = '0;
    end

    task automatic push(int i, logic [7:0] d, bit l);
        mem[i][tl[i]] = d;
        lm[i][tl[i]] = l;
        tl[i]++;
    endtask

    // Observation logs of DUT events
    int gr_id[$];
    int gr_cyc[$];
    int en_cyc[$];
    int en_dat[$];
    int done_cyc[$];
    int err_cyc[$];

    // Reference model: frame age since grant, whether busy was seen, pending DONE
    int         m_g = N - 1;
    bit         m_act = 0;
    int         m_age = 0;
    bit         m_fell = 0;
    bit         m_done = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_lock = 0;

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        bit e_en, e_err;
        int w, j;
        if (!rst_n) begin
            m_g = N - 1; m_act = 0; m_age = 0; m_fell = 0;
            m_done = 0; m_data = 8'h00; m_lock = 0;
            chk("rst_ready", int'(req_ready), 0);
            chk("rst_en", int'(tx_en), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done_err", int'({done, err}), 0);
            chk("rst_data", int'(tx_data), 0);
            chk("rst_gid", int'(grant_id), N - 1);
        end else begin
            e_en = m_act && m_age == 1;
            e_err = m_act && !m_fell && m_age == 2 + TO;
            e_ready = '0;
            w = -1;
            if (!m_act && tx_status) begin
                for (int s = 1; s <= N; s++) begin
                    j = (m_g + s) % N;
                    if (w < 0 && req_valid[j] && (!m_lock || j == m_g)) w = j;
                end
                if (w >= 0) e_ready[w] = 1'b1;
            end
            chk("ready", int'(req_ready), int'(e_ready));
            chk("tx_en", int'(tx_en), int'(e_en));
            chk("err", int'(err), int'(e_err));
            chk("done", int'(done), int'(m_done));
            chk("busy", int'(busy), int'(m_act));
            chk("tx_data", int'(tx_data), int'(m_data));
            chk("grant_id", int'(grant_id), m_g);

            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin gr_id.push_back(i); gr_cyc.push_back(cyc); end
            if (tx_en) begin en_cyc.push_back(cyc); en_dat.push_back(int'(tx_data)); end
            if (done) done_cyc.push_back(cyc);
            if (err) err_cyc.push_back(cyc);
            acc = req_ready;

            m_done = 0;
            if (w >= 0) begin
                m_act = 1; m_age = 1; m_fell = 0; m_g = w;
                m_data = req_data[w*8 +: 8];
`ifdef UART_TX_SCHED_LOCK_EN
                m_lock = !req_last[w];
`endif
            end else if (m_act) begin
                if (e_err) begin
                    m_act = 0; m_lock = 0;
                end else if (m_fell) begin
                    if (tx_status) begin m_done = 1; m_act = 0; end
                end else if (m_age >= 2 && !tx_status) m_fell = 1;
                if (m_act) m_age++;
            end
        end
    end

    function automatic int count(int kind);
        case (kind)
            0: return done_cyc.size();
            1: return err_cyc.size();
            2: return en_cyc.size();
            default: return gr_id.size();
        endcase
    endfunction

    task automatic wait_until(string nm, int kind, int target, int budget);
        for (int i = 0; i < budget; i++) begin
            if (count(kind) >= target) break;
            @(posedge clk);
        end
        chk(nm, int'(count(kind) >= target), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int g0, d0, e0, n0;
        int exp_order[4];
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_gid", int'(grant_id), 3);
        chk("init_busy", int'(busy), 0);

        // Single byte, 9-cycle busy transmitter
        @(posedge clk); #1;
        g0 = gr_id.size(); d0 = done_cyc.size(); e0 = en_cyc.size();
        xmode = 0; xb = 9;
        push(2, 8'hA5, 1'b1);
        wait_until("s1_done", 0, d0 + 1, 60);
        chk("s1_gid", gr_id[g0], 2);
        chk("s1_en_lat", en_cyc[e0] - gr_cyc[g0], 1);
        chk("s1_en_data", en_dat[e0], 8'hA5);
        chk("s1_done_lat", done_cyc[d0] - gr_cyc[g0], 12);
        chk("s1_grant_id", int'(grant_id), 2);

        // All four valid from reset: order 0,1,2,3,0
        do_reset();
        g0 = gr_id.size(); d0 = done_cyc.size(); e0 = en_cyc.size();
        xb = 2;
        push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
        push(3, 8'h44, 1'b1); push(0, 8'h55, 1'b1);
        wait_until("s2_done", 0, d0 + 5, 200);
        chk("s2_g0", gr_id[g0], 0);
        chk("s2_g1", gr_id[g0 + 1], 1);
        chk("s2_g2", gr_id[g0 + 2], 2);
        chk("s2_g3", gr_id[g0 + 3], 3);
        chk("s2_g4", gr_id[g0 + 4], 0);
        chk("s2_d1", en_dat[e0 + 1], 8'h22);
        chk("s2_d3", en_dat[e0 + 3], 8'h44);
        chk("s2_d4", en_dat[e0 + 4], 8'h55);

        // Transmitter never goes busy: timeout, then next requester
        @(posedge clk); #1;
        xmode = 1;
        g0 = gr_id.size(); d0 = done_cyc.size(); e0 = err_cyc.size();
        push(1, 8'h66, 1'b1); push(2, 8'h77, 1'b1);
        wait_until("s3_err", 1, e0 + 2, 60);
        chk("s3_first", gr_id[g0], 1);
        chk("s3_err_lat", err_cyc[e0] - gr_cyc[g0], 6);
        chk("s3_regrant", gr_cyc[g0 + 1] - err_cyc[e0], 1);
        chk("s3_next", gr_id[g0 + 1], 2);
        chk("s3_no_done", done_cyc.size(), d0);

        // Reset while waiting for the frame to finish
        @(posedge clk); #1;
        xmode = 0; xb = 20;
        e0 = en_cyc.size();
        push(1, 8'h99, 1'b1);
        wait_until("s4_en", 2, e0 + 1, 30);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("s4_en", int'(tx_en), 0);
        chk("s4_busy", int'(busy), 0);
        chk("s4_data", int'(tx_data), 0);
        chk("s4_gid", int'(grant_id), 3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        g0 = gr_id.size(); d0 = done_cyc.size();
        push(0, 8'hAA, 1'b1); push(2, 8'hBB, 1'b1);
        wait_until("s4_done", 0, d0 + 2, 150);
        chk("s4_after0", gr_id[g0], 0);
        chk("s4_after1", gr_id[g0 + 1], 2);

        // Transmitter stuck busy in IDLE: nothing is granted
        @(posedge clk); #1;
        xmode = 2;
        @(posedge clk); #1;
        g0 = gr_id.size(); e0 = en_cyc.size(); d0 = done_cyc.size();
        push(3, 8'hCC, 1'b1);
        repeat (10) @(posedge clk);
        chk("s5_no_ready", gr_id.size(), g0);
        chk("s5_no_en", en_cyc.size(), e0);
        #1 xmode = 0; xb = 3;
        wait_until("s5_done", 0, d0 + 1, 40);
        chk("s5_gid", gr_id[g0], 3);
        chk("s5_data", en_dat[e0], 8'hCC);

        // Burst from requester 1 competing with requester 0
        @(posedge clk); #1;
        d0 = done_cyc.size();
        push(0, 8'hD0, 1'b1);
        wait_until("s6_pre", 0, d0 + 1, 40);
        @(posedge clk); #1;
        g0 = gr_id.size(); d0 = done_cyc.size(); n0 = en_cyc.size();
        push(1, 8'hE1, 1'b0); push(1, 8'hE2, 1'b0); push(1, 8'hE3, 1'b1);
        push(0, 8'hF0, 1'b1);
`ifdef UART_TX_SCHED_LOCK_EN
        exp_order = '{1, 1, 1, 0};
`else
        exp_order = '{1, 0, 1, 1};
`endif
        wait_until("s6_done", 0, d0 + 4, 150);
        for (int i = 0; i < 4; i++)
            chk($sformatf("s6_order%0d", i), gr_id[g0 + i], exp_order[i]);
        chk("s6_first_data", en_dat[n0], 8'hE1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
